// File: rtl/alu_bf_pkg.sv
// alu_bf_pkg
// Shared definitions for the bit-field / bitwise-logic unit: the operation
// code enumeration, its width, and a helper that recognises the reserved
// operation codes.
package alu_bf_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND      = 3'b000,
      OP_OR       = 3'b001,
      OP_XOR      = 3'b010,
      OP_TRUNC_LO = 3'b011,
      OP_TRUNC_HI = 3'b100,
      OP_BITSEL   = 3'b101
   } op_e;

   // Codes 110 and 111 have no operation; they produce a zero result and
   // raise the error flag.
   function automatic logic is_reserved(input logic [OP_W-1:0] op);
      return (op == 3'b110) || (op == 3'b111);
   endfunction

endpackage

// File: rtl/alu_bf_mask_gen.sv
// alu_bf_mask_gen
// Combinational mask generator for the mask-based operations.
// Ports:
//   op   in  OP_W   operation code
//   amt  in  AW     bit position / count (unsigned)
//   mask out WIDTH  mask to AND with operand A (all zero for non-mask ops)
module alu_bf_mask_gen
   import alu_bf_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input  logic [OP_W-1:0]  op,
   input  logic [AW-1:0]    amt,
   output logic [WIDTH-1:0] mask
);

   logic [WIDTH-1:0] lo_mask;
   logic [WIDTH-1:0] sel_mask;
   op_e              op_sel;

   assign op_sel = op_e'(op);

   // Each mask bit is a direct comparison of its own index against amt, so
   // amounts at or beyond WIDTH saturate naturally instead of wrapping a shift.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign lo_mask[i]  = (AW'(i) <  amt);
      assign sel_mask[i] = (AW'(i) == amt);
   end

   // Pick the mask shape for the requested operation.
   always_comb begin
      mask = '0;
      case (op_sel)
         OP_TRUNC_LO: mask = lo_mask;
         OP_TRUNC_HI: mask = ~lo_mask;
         OP_BITSEL:   mask = sel_mask;
         default:     mask = '0;
      endcase
   end

endmodule

// File: rtl/alu_bitfield_unit.sv
// alu_bitfield_unit
// Two-stage pipelined bitwise-logic and bit-field unit with valid/ready flow
// control. Stage 1 captures the request and its precomputed mask; stage 2
// holds the result that drives the outputs.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   op, x, y, amt       operation, operands, bit position / count
//   out_valid/out_ready result handshake
//   f, zero, err        result, result-is-zero flag, reserved-op flag
module alu_bitfield_unit
   import alu_bf_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [AW-1:0]    amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             zero,
   output logic             err
);

   logic             s1_valid;
   logic [OP_W-1:0]  s1_op;
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y;
   logic [WIDTH-1:0] s1_mask;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_f;
   logic             s2_zero;
   logic             s2_err;

   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] f_next;
   logic             s2_free;
   logic             s1_advance;
   logic             accept;

   alu_bf_mask_gen #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_mask_gen (
      .op   (op),
      .amt  (amt),
      .mask (mask)
   );

   // Handshake: readiness depends only on stage occupancy and out_ready,
   // never on in_valid.
   assign s2_free    = !s2_valid || out_ready;
   assign s1_advance = s1_valid && s2_free;
   assign in_ready   = !s1_valid || s2_free;
   assign accept     = in_valid && in_ready;

   // Stage 1: capture the request. A new accept takes priority over
   // draining, so a same-cycle advance and accept leaves no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_mask  <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_op    <= op;
         s1_x     <= x;
         s1_y     <= y;
         s1_mask  <= mask;
      end else if (s1_advance) begin
         s1_valid <= 1'b0;
      end
   end

   // Result select from the stage 1 contents.
   always_comb begin
      f_next = '0;
      case (op_e'(s1_op))
         OP_AND:      f_next = s1_x & s1_y;
         OP_OR:       f_next = s1_x | s1_y;
         OP_XOR:      f_next = s1_x ^ s1_y;
         OP_TRUNC_LO,
         OP_TRUNC_HI,
         OP_BITSEL:   f_next = s1_x & s1_mask;
         default:     f_next = '0;
      endcase
   end

   // Stage 2: load on advance; otherwise hold while the consumer stalls and
   // empty once the result has been taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_f     <= '0;
         s2_zero  <= 1'b0;
         s2_err   <= 1'b0;
      end else if (s1_advance) begin
         s2_valid <= 1'b1;
         s2_f     <= f_next;
         s2_zero  <= (f_next == '0);
         s2_err   <= is_reserved(s1_op);
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   assign out_valid = s2_valid;
   assign f         = s2_f;
   assign zero      = s2_zero;
   assign err       = s2_err;

endmodule
